// File: rtl/bicubic_pkg.sv
// bicubic_pkg: shared constants, column-beat layout and width helper for the line buffer
package bicubic_pkg;
  localparam int N_TAPS = 4;
  localparam int N_BANKS = 4;
  localparam int DEF_DW = 24;
  localparam int DEF_IMG_W = 960;
  localparam int DEF_IMG_H = 540;
  typedef struct packed {
    logic [N_TAPS*DEF_DW-1:0] taps;
    logic [$clog2(DEF_IMG_W)-1:0] x;
    logic [$clog2(DEF_IMG_H)-1:0] y;
    logic eol;
  } col_beat_t;
  function automatic int beat_w(int dw, int aw, int yw);
    return N_TAPS * dw + aw + yw + 1;
  endfunction
endpackage

// File: rtl/bicubic_linebuf_ctrl_col_skid_fifo.sv
// col_skid_fifo: 3-entry FIFO (clk, rst async, push/din in, pop in, dout/cnt out); dout holds while not popped
module col_skid_fifo
  import bicubic_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   cnt
);
  logic [W-1:0] mem [3];
  logic [1:0] rp, wp;
  assign dout = mem[rp];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rp <= '0;
      wp <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp == 2'd2 ? 2'd0 : wp + 2'd1;
      if (pop) rp <= rp == 2'd2 ? 2'd0 : rp + 2'd1;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end
  always_ff @(posedge clk) if (push) mem[wp] <= din;
endmodule

// File: rtl/bicubic_linebuf_ctrl.sv
// bicubic_linebuf_ctrl: rotating 4-bank line buffer emitting 4-tap vertical columns (in_* stream in, sram_* bank port, col_* stream out, frame_done pulse)
module bicubic_linebuf_ctrl
  import bicubic_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int AW = $clog2(IMG_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DW-1:0]            in_data,
  input  logic                     in_sof,
  output logic                     col_valid,
  input  logic                     col_ready,
  output logic [N_TAPS*DW-1:0]     col_data,
  output logic [AW-1:0]            col_x,
  output logic [$clog2(IMG_H)-1:0] col_y,
  output logic                     col_eol,
  output logic                     frame_done,
  output logic [AW-1:0]            sram_addr,
  output logic [N_BANKS-1:0]       sram_cs_n,
  output logic [N_BANKS-1:0]       sram_wr_en,
  output logic [DW-1:0]            sram_wdata,
  input  logic [N_BANKS*DW-1:0]    sram_rdata
);
  localparam int YW = $clog2(IMG_H);
  localparam int BW = beat_w(DW, AW, YW);
  localparam logic [0:0] IDLE = 1'b0, ACTIVE = 1'b1;
  logic [0:0] state;
  logic [AW-1:0] x, ex, p1_x;
  logic [YW-1:0] y, ey, p1_y;
  logic [1:0] bank, eb, p1_bank, b0, b1, b2, fifo_cnt;
  logic [DW-1:0] p1_pix, t0, t1, t2;
  logic p1_valid, acc, eol_in, last_pix, pop;
  logic [BW-1:0] beat, fifo_out;
  assign in_ready = state == IDLE || (3'(fifo_cnt) + 3'(p1_valid)) < 3'd3;
  assign acc = in_valid && in_ready && (state == ACTIVE || in_sof);
  // in_sof forces the beat to be treated as the frame origin
  assign ex = in_sof ? '0 : x;
  assign ey = in_sof ? '0 : y;
  assign eb = in_sof ? '0 : bank;
  assign eol_in = ex == AW'(IMG_W - 1);
  assign last_pix = eol_in && ey == YW'(IMG_H - 1);
  assign sram_addr = ex;
  assign sram_cs_n = acc ? '0 : '1;
  assign sram_wr_en = acc ? N_BANKS'(1) << eb : '0;
  assign sram_wdata = in_data;
  // older rows live in the banks after the write bank, oldest first
  assign b0 = p1_bank + 2'd1;
  assign b1 = p1_bank + 2'd2;
  assign b2 = p1_bank + 2'd3;
  // rows above the frame replicate the topmost valid row
  always_comb begin
    t2 = p1_y == 0 ? p1_pix : sram_rdata[b2*DW +: DW];
    t1 = p1_y == 0 ? p1_pix : p1_y == 1 ? sram_rdata[b2*DW +: DW] : sram_rdata[b1*DW +: DW];
    t0 = p1_y == 0 ? p1_pix : p1_y == 1 ? sram_rdata[b2*DW +: DW] :
         p1_y == 2 ? sram_rdata[b1*DW +: DW] : sram_rdata[b0*DW +: DW];
  end
  assign beat = {p1_pix, t2, t1, t0, p1_x, p1_y, p1_x == AW'(IMG_W - 1)};
  assign {col_data, col_x, col_y, col_eol} = fifo_out;
  assign col_valid = fifo_cnt != 2'd0;
  assign pop = col_valid && col_ready;
  col_skid_fifo #(.W(BW)) u_fifo (
    .clk(clk), .rst(rst), .push(p1_valid), .din(beat), .pop(pop), .dout(fifo_out), .cnt(fifo_cnt)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      x <= '0;
      y <= '0;
      bank <= '0;
      p1_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      p1_valid <= acc;
      frame_done <= pop && col_eol && col_y == YW'(IMG_H - 1);
      if (acc) begin
        x <= eol_in ? '0 : ex + 1'b1;
        y <= eol_in ? (last_pix ? '0 : ey + 1'b1) : ey;
        bank <= eol_in ? eb + 2'd1 : eb;
        state <= last_pix ? IDLE : ACTIVE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (acc) begin
      p1_pix <= in_data;
      p1_x <= ex;
      p1_y <= ey;
      p1_bank <= eb;
    end
  end
endmodule

// File: doc/bicubic_linebuf_ctrl.md
Name: bicubic_linebuf_ctrl

Overview:
Sequences four single-port line SRAM banks (DEPTH = IMG_W, 1-cycle read latency, cs_n/wr_en interface, read data zeroed when deselected) as a rotating 4-line buffer for the bicubic upscaler. Each accepted input pixel is written into the current-row bank. The same column is read from the three older banks in the same cycle. The block emits a 4-tap vertical column (rows y-3..y) with top-border replication into a 3-entry output FIFO, under valid/ready flow control on both sides.

Parameters:
DW, 24, pixel width (RGB888)
IMG_W, 960, pixels per row; also the bank depth
IMG_H, 540, rows per frame
AW, $clog2(IMG_W), bank address width (derived; do not override)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  input pixel valid
in_ready  out  1  input pixel accepted when in_valid & in_ready
in_data  in  DW  input pixel
in_sof  in  1  marks row 0 / column 0 of a frame
col_valid  out  1  output column valid
col_ready  in  1  downstream accepts column
col_data  out  4*DW  taps; [DW-1:0] = row y-3 (oldest) … [4*DW-1:3*DW] = row y (live)
col_x  out  AW  column index of output
col_y  out  $clog2(IMG_H)  row index y of output
col_eol  out  1  col_x == IMG_W-1
frame_done  out  1  one-cycle pulse after last column of row IMG_H-1 leaves the block
sram_addr  out  AW  shared address to all banks
sram_cs_n  out  4  per-bank chip select, active low
sram_wr_en  out  4  per-bank write enable
sram_wdata  out  DW  shared write data (= in_data)
sram_rdata  in  4*DW  bank read data, bank b at [b*DW +: DW]

Behaviour:
- Reset (async): state IDLE; x, y, wr_bank, p1_valid and FIFO count cleared. Outputs: col_valid=0, frame_done=0, sram_cs_n=4'hF, sram_wr_en=0. in_ready follows its definition below, which evaluates to 1 in IDLE.
- FSM IDLE: in_ready=1. Beats without in_sof are discarded with no SRAM access. A beat with in_sof goes to ACTIVE and is processed as x=0, y=0, wr_bank=0.
- FSM ACTIVE: in_ready = (fifo_cnt + p1_valid) < 3. Never depends combinationally on col_ready.
- Accept cycle (ACTIVE, or IDLE with in_sof):
  - sram_addr = x; sram_cs_n = 0 for all banks; sram_wr_en = one-hot(wr_bank); sram_wdata = in_data.
  - Non-accept cycles: cs_n=4'hF, wr_en=0. SRAM outputs are not relied on outside p1 capture.
- Latency:
  - Accept at edge T loads p1 (live pixel, x, y, wr_bank).
  - At edge T+1 p1 pushes into the FIFO, using sram_rdata from the three non-write banks.
  - col_valid rises the cycle after T+1 if the FIFO was empty. Steady throughput is 1 column/cycle.
  - p1 always advances; the in_ready rule guarantees FIFO space.
- Tap mapping at push: tap3 = live pixel; tap k (k=0..2) = bank (wr_bank - 3 + k) mod 4.
- Top-border replication: any tap whose row y-3+k < 0 takes the nearest valid row at or above 0.
  - y=0: all taps = live.
  - y=1: taps0..2 = row 0.
  - y=2: tap0 = tap1 = row 0.
- Counters:
  - x increments per accept. At x=IMG_W-1: x wraps to 0, y increments, wr_bank increments mod 4.
  - After the accept with y=IMG_H-1, x=IMG_W-1, the FSM returns to IDLE.
  - frame_done pulses when that column pops from the FIFO.
- in_sof in ACTIVE: restarts the frame (x=y=wr_bank=0) with that beat. Columns already in p1/FIFO drain unchanged.
- FIFO: 3 entries holding {taps, x, y, eol}. Push from p1 and pop (col_valid & col_ready) in the same cycle are both honoured. col_* outputs are stable while col_valid & !col_ready.
- Bottom-border rows (y > IMG_H-1) are not generated; downstream owns bottom padding.

Decomposition:
- bicubic_pkg: N_TAPS=4, N_BANKS=4, default DW/IMG_W/IMG_H, and a column-beat struct/width constant {taps, x, y, eol}.
- Sub-module col_skid_fifo: 3-entry synchronous FIFO with count output, reused by the output stage.

Test Plan:
- Reset mid-stream (rst pulse while p1 and FIFO are occupied) -> same cycle: col_valid=0, sram_cs_n=4'hF; next in_sof beat is processed as x=0, y=0.
- IMG_W=8, IMG_H=6, ramp pixel value = 16*y + x, col_ready=1 -> first col_valid 2 cycles after first accept. Row 0 taps all = x. Row 1 taps = {x, x, x, 16+x}. Row 4, x=3 taps = {0x13, 0x23, 0x33, 0x43}.
- Steady stream with col_ready=1 -> in_ready stays 1; one column per cycle; bank write pattern wr_en=0001, 0010, 0100, 1000, 0001 across rows 0..4.
- Hold col_ready=0 for 10 cycles -> exactly 3 columns buffered, in_ready=0, col_data stable. Release -> columns emerge in order with no loss or duplication.
- Beats before in_sof -> no SRAM access (cs_n=4'hF), no output. in_sof mid-frame at y=3 -> next column has y=0 with taps all = live.
- Last pixel of frame accepted -> FSM returns to IDLE. frame_done pulses for exactly 1 cycle on the pop of the column with x=7, y=5.
